// File: rtl/dds_ctrl_pkg.sv
// Shared types and constants for the DDS phase-step controller.
package dds_ctrl_pkg;

  localparam int unsigned STEP_W = 32;
  localparam int unsigned BTN_W  = 6;

  localparam int unsigned BTN_COARSE_ADD = 0;
  localparam int unsigned BTN_COARSE_SUB = 1;
  localparam int unsigned BTN_MID_ADD    = 2;
  localparam int unsigned BTN_MID_SUB    = 3;
  localparam int unsigned BTN_FINE_ADD   = 4;
  localparam int unsigned BTN_FINE_SUB   = 5;

  localparam logic [STEP_W-1:0] DEF_STEP_MIN     = 32'd10000;
  localparam logic [STEP_W-1:0] DEF_STEP_MAX     = 32'd2000000;
  localparam logic [STEP_W-1:0] DEF_DELTA_COARSE = 32'd10000;
  localparam logic [STEP_W-1:0] DEF_DELTA_MID    = 32'd1000;
  localparam logic [STEP_W-1:0] DEF_DELTA_FINE   = 32'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_APPLY,
    ST_HOLD,
    ST_RELEASE
  } state_e;

endpackage

// File: rtl/dds_step_controller_if.sv
// Front-panel button / step-word bundle between the panel side and the controller.
interface dds_step_controller_if;
  import dds_ctrl_pkg::*;

  logic [BTN_W-1:0]  btn_n;
  logic [STEP_W-1:0] step;
  logic              step_update;
  logic              sat_flag;
  logic              busy;

  modport master (output btn_n, input step, step_update, sat_flag, busy);
  modport slave  (input btn_n, output step, step_update, sat_flag, busy);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser with a parameterised asynchronous reset value.
module sync_2ff #(
  parameter int unsigned W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dds_step_controller.sv
// Debounced button-driven DDS step word with saturation; one apply per accepted press.
// Define AUTO_REPEAT_EN to enable auto-repeat while a button vector is held.
module dds_step_controller
  import dds_ctrl_pkg::*;
#(
  parameter logic [STEP_W-1:0] STEP_MIN     = DEF_STEP_MIN,
  parameter logic [STEP_W-1:0] STEP_MAX     = DEF_STEP_MAX,
  parameter logic [STEP_W-1:0] DELTA_COARSE = DEF_DELTA_COARSE,
  parameter logic [STEP_W-1:0] DELTA_MID    = DEF_DELTA_MID,
  parameter logic [STEP_W-1:0] DELTA_FINE   = DEF_DELTA_FINE,
  parameter int unsigned       DEBOUNCE_CYCLES = 500000
`ifdef AUTO_REPEAT_EN
  , parameter int unsigned     REPEAT_DELAY    = 25000000
  , parameter int unsigned     REPEAT_PERIOD   = 5000000
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  dds_step_controller_if.slave bus
);

  localparam int unsigned     CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
  localparam int unsigned     RPT_W    = (REPEAT_DELAY > 2) ? $clog2(REPEAT_DELAY) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_DELAY - 1);
  // Count value after an auto-repeat apply so the next one lands REPEAT_PERIOD later.
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);
  logic [RPT_W-1:0] rpt;
`endif

  state_e            state;
  logic [BTN_W-1:0]  btn_sync;
  logic [BTN_W-1:0]  pressed;
  logic [BTN_W-1:0]  cand;
  logic [CNT_W-1:0]  cnt;
  logic [STEP_W-1:0] step_q;
  logic              step_update_q;
  logic              sat_q;
  logic              busy_q;

  sync_2ff #(.W(BTN_W), .RST_VAL({BTN_W{1'b1}})) u_sync (
    .clk (clk),
    .rst (reset),
    .d   (bus.btn_n),
    .q   (btn_sync)
  );

  assign pressed = ~btn_sync;

  // Priority select (bit 0 wins) and saturating update, 33-bit intermediates.
  logic [STEP_W-1:0] delta_c;
  logic              is_add_c;
  logic [STEP_W:0]   sum_c;
  logic [STEP_W:0]   lim_c;
  logic [STEP_W-1:0] next_step_c;
  logic              next_sat_c;

  always_comb begin
    delta_c     = '0;
    is_add_c    = 1'b0;
    next_step_c = step_q;
    next_sat_c  = 1'b0;
    if      (cand[BTN_COARSE_ADD]) begin delta_c = DELTA_COARSE; is_add_c = 1'b1; end
    else if (cand[BTN_COARSE_SUB]) begin delta_c = DELTA_COARSE; end
    else if (cand[BTN_MID_ADD])    begin delta_c = DELTA_MID;    is_add_c = 1'b1; end
    else if (cand[BTN_MID_SUB])    begin delta_c = DELTA_MID;    end
    else if (cand[BTN_FINE_ADD])   begin delta_c = DELTA_FINE;   is_add_c = 1'b1; end
    else if (cand[BTN_FINE_SUB])   begin delta_c = DELTA_FINE;   end
    sum_c = {1'b0, step_q} + {1'b0, delta_c};
    lim_c = {1'b0, STEP_MIN} + {1'b0, delta_c};
    if (is_add_c) begin
      if (sum_c > {1'b0, STEP_MAX}) begin
        next_step_c = STEP_MAX;
        next_sat_c  = 1'b1;
      end else begin
        next_step_c = sum_c[STEP_W-1:0];
      end
    end else if ({1'b0, step_q} < lim_c) begin
      next_step_c = STEP_MIN;
      next_sat_c  = 1'b1;
    end else begin
      next_step_c = step_q - delta_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      cand          <= '0;
      cnt           <= '0;
      step_q        <= STEP_MIN;
      step_update_q <= 1'b0;
      sat_q         <= 1'b0;
      busy_q        <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rpt           <= '0;
`endif
    end else begin
      step_update_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pressed != '0) begin
            cand   <= pressed;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (pressed == '0) begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end else if (pressed != cand) begin
            cand <= pressed;
            cnt  <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_APPLY;
`ifdef AUTO_REPEAT_EN
            rpt   <= RPT_W'(1);
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_APPLY: begin
          step_q        <= next_step_c;
          sat_q         <= next_sat_c;
          step_update_q <= 1'b1;
          state         <= ST_HOLD;
        end
        ST_HOLD: begin
          if (pressed == '0) begin
            cnt   <= '0;
            state <= ST_RELEASE;
          end
`ifdef AUTO_REPEAT_EN
          else if (pressed != cand) begin
            cand <= pressed;
            rpt  <= RPT_W'(1);
          end else if (rpt == RPT_LAST) begin
            rpt   <= RPT_RELOAD;
            state <= ST_APPLY;
          end else begin
            rpt <= rpt + RPT_W'(1);
          end
`endif
        end
        ST_RELEASE: begin
          if (pressed != '0) begin
            state <= ST_HOLD;
`ifdef AUTO_REPEAT_EN
            cand  <= pressed;
            rpt   <= RPT_W'(1);
`endif
          end else if (cnt == CNT_LAST) begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.step        = step_q;
  assign bus.step_update = step_update_q;
  assign bus.sat_flag    = sat_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_dds_step_controller.sv
// Scoreboard bench for dds_step_controller; honours AUTO_REPEAT_EN when defined.
module tb_dds_step_controller;

  localparam int unsigned DB   = 4;
`ifdef AUTO_REPEAT_EN
  localparam int unsigned RD   = 20;
  localparam int unsigned RP   = 8;
`endif
  localparam longint      SMIN = 10000;
  localparam longint      SMAX = 2000000;

  typedef struct {
    longint step;
    bit     sat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dds_step_controller_if bus ();

  dds_step_controller #(
    .STEP_MIN        (32'd10000),
    .STEP_MAX        (32'd2000000),
    .DELTA_COARSE    (32'd10000),
    .DELTA_MID       (32'd1000),
    .DELTA_FINE      (32'd1),
    .DEBOUNCE_CYCLES (DB)
`ifdef AUTO_REPEAT_EN
    , .REPEAT_DELAY  (RD)
    , .REPEAT_PERIOD (RP)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t   q[$];
  longint model_step = SMIN;
  longint last_step  = SMIN;
  bit     last_sat   = 1'b0;
  int     checks     = 0;
  int     errors     = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: lowest set bit picks the operation; result clipped to the bounds.
  function automatic void apply_model(input logic [5:0] vec);
    int     idx = 0;
    longint d;
    exp_t   e;
    for (int i = 5; i >= 0; i--) if (vec[i]) idx = i;
    case (idx / 2)
      0:       d = 10000;
      1:       d = 1000;
      default: d = 1;
    endcase
    if (idx % 2 == 0) begin
      if (model_step + d > SMAX) begin e.step = SMAX; e.sat = 1'b1; end
      else begin e.step = model_step + d; e.sat = 1'b0; end
    end else begin
      if (model_step < SMIN + d) begin e.step = SMIN; e.sat = 1'b1; end
      else begin e.step = model_step - d; e.sat = 1'b0; end
    end
    model_step = e.step;
    q.push_back(e);
  endfunction

  // Applies for a clean hold of L cycles: first at press+DB+4, then +RD, then every +RP;
  // an apply at edge a still happens if the pins were low up to edge a-3.
  function automatic int num_applies(input int len);
    int n = 1;
`ifdef AUTO_REPEAT_EN
    int a = DB + 4 + RD;
    while (a <= len + 3) begin
      n++;
      a += RP;
    end
`endif
    return n;
  endfunction

  task automatic drive(input logic [5:0] vec, input int cycles);
    bus.btn_n = ~vec;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [5:0] vec, input int len, input int gap);
    int n = num_applies(len);
    for (int i = 0; i < n; i++) apply_model(vec);
    drive(vec, len);
    drive(6'd0, gap);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_step = SMIN;
  endtask

  // Monitor: pops on every step_update, otherwise step and sat_flag must hold.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      checks++;
      if (bus.step !== 32'd10000 || bus.step_update !== 1'b0 || bus.sat_flag !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs actual step=%0d upd=%b sat=%b busy=%b required step=10000 upd=0 sat=0 busy=0",
                 bus.step, bus.step_update, bus.sat_flag, bus.busy);
      end
      last_step = SMIN;
      last_sat  = 1'b0;
    end else if (bus.step_update === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_update actual step=%0d sat=%b required no pulse", bus.step, bus.sat_flag);
      end else begin
        e = q.pop_front();
        if (longint'(bus.step) != e.step || bus.sat_flag !== e.sat) begin
          errors++;
          $display("FAIL applied_step actual step=%0d sat=%b required step=%0d sat=%b",
                   bus.step, bus.sat_flag, e.step, e.sat);
        end
        last_step = e.step;
        last_sat  = e.sat;
      end
    end else begin
      checks++;
      if (longint'(bus.step) != last_step || bus.sat_flag !== last_sat) begin
        errors++;
        $display("FAIL step_hold actual step=%0d sat=%b required step=%0d sat=%b",
                 bus.step, bus.sat_flag, last_step, last_sat);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [5:0] vec;
    reset     = 1'b1;
    bus.btn_n = 6'h3f;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_busy", longint'(bus.busy), 0);
    check("reset_step", longint'(bus.step), SMIN);

    // 1: coarse add with latency measurement
    apply_model(6'b000001);
    lat = 0;
    bus.btn_n = ~6'b000001;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 5) check("busy_debounce", longint'(bus.busy), 1);
      if (bus.step_update === 1'b1 && lat == 0) lat = k;
    end
    drive(6'd0, 10);
    check("latency", lat, DB + 4);
    check("t1_step", longint'(bus.step), 20000);
    check("t1_sat", longint'(bus.sat_flag), 0);
    check("t1_idle", longint'(bus.busy), 0);

    // 2: bouncing fine add, then stable hold
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(6'b010000, 2);
      drive(6'd0, 2);
    end
    press(6'b010000, 10, 10);
    check("t2_step", longint'(bus.step), 10001);

    // 3: clip at both bounds
    do_reset();
    press(6'b000100, 6, 8);
    press(6'b000010, 6, 8);
    check("t3_min_step", longint'(bus.step), SMIN);
    check("t3_min_sat", longint'(bus.sat_flag), 1);
    for (int i = 0; i < 198; i++) press(6'b000001, 6, 8);
    for (int i = 0; i < 5; i++) press(6'b000100, 6, 8);
    check("t3_pre_max", longint'(bus.step), 1995000);
    press(6'b000001, 6, 8);
    check("t3_max_step", longint'(bus.step), SMAX);
    check("t3_max_sat", longint'(bus.sat_flag), 1);
    press(6'b000001, 6, 8);
    press(6'b100000, 6, 8);
    check("t3_after_fine_sub", longint'(bus.step), 1999999);
    check("t3_sat_clear", longint'(bus.sat_flag), 0);

    // 4: simultaneous add/sub, re-press inside release window
    do_reset();
    apply_model(6'b000011);
    drive(6'b000011, 8);
    drive(6'd0, 2);
    drive(6'b000011, 8);
    drive(6'd0, 12);
    check("t4_step", longint'(bus.step), 20000);
    check("t4_drained", q.size(), 0);

    // 5: reset in DEBOUNCE, then in HOLD at step 30000
    do_reset();
    drive(6'b000001, 5);
    reset = 1'b1;
    #1;
    check("t5_deb_step", longint'(bus.step), SMIN);
    check("t5_deb_busy", longint'(bus.busy), 0);
    bus.btn_n = 6'h3f;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_step = SMIN;
    drive(6'd0, 12);
    check("t5_no_apply", longint'(bus.step), SMIN);
    press(6'b000001, 6, 8);
    apply_model(6'b000001);
    drive(6'b000001, 12);
    check("t5_hold_busy", longint'(bus.busy), 1);
    check("t5_hold_step", longint'(bus.step), 30000);
    reset = 1'b1;
    #1;
    check("t5_hold_reset_step", longint'(bus.step), SMIN);
    check("t5_hold_reset_upd", longint'(bus.step_update), 0);
    bus.btn_n = 6'h3f;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_step = SMIN;
    drive(6'd0, 10);

    // 6: long hold of mid add
    press(6'b000100, 46, 10);
`ifdef AUTO_REPEAT_EN
    check("t6_step", longint'(bus.step), 14000);
`else
    check("t6_step", longint'(bus.step), 11000);
`endif

    // Randomised clean presses with optional bounce prefix
    for (int i = 0; i < 30; i++) begin
      vec = 6'($urandom_range(1, 63));
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b < int'($urandom_range(1, 3)); b++) begin
          drive(vec, int'($urandom_range(1, 3)));
          drive(6'd0, int'($urandom_range(1, 3)));
        end
      end
      press(vec, int'($urandom_range(6, 60)), int'($urandom_range(8, 14)));
      check("rand_step", longint'(bus.step), model_step);
    end

    drive(6'd0, 20);
    check("final_drained", q.size(), 0);
    check("final_idle", longint'(bus.busy), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
